pipeline_ctrl: RTL and testbench

Parametrised pipeline control unit that replaces the fixed 6-bit stall/flush controller. It merges per-stage stall requests into a thermometer stall vector and sequences exception entry and return through a small state machine. It also holds the flush for a configurable number of cycles and watches for stalls that never release. It sits beside the pipeline registers, receives exception status from the MEM stage and EPC from CP0, and drives the PC and all pipeline registers.

---
 rtl/pipeline_ctrl_pkg.sv | 38 +++
 rtl/pipeline_ctrl_stall_thermo.sv | 19 +
 rtl/pipeline_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared codes, constants and FSM encoding for pipeline_ctrl
package pipeline_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic        RESET_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        VSEL_GEN = 2'd0,
        VSEL_INT = 2'd1,
        VSEL_EPC = 2'd2
    } vec_sel_e;

    // Unknown nonzero codes fall back to the general vector.
    function automatic vec_sel_e exc_vec_sel(input logic [31:0] code);
        vec_sel_e sel;
        case (code)
            EXC_INT:                            sel = VSEL_INT;
            EXC_ERET:                           sel = VSEL_EPC;
            EXC_SYS, EXC_INV, EXC_OV, EXC_TRAP: sel = VSEL_GEN;
            default:                            sel = VSEL_GEN;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_thermo.sv
// rtl/pipeline_ctrl_stall_thermo.sv - highest-set-bit to thermometer encoder
module stall_thermo #(
    parameter int N = 6
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] therm_o
);

    always_comb begin
        logic acc;
        therm_o = '0;
        acc     = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            acc        = acc | req_i[j];
            therm_o[j] = acc;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall merge, exception freeze/flush sequencing and stall watchdog
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int              NSTAGE        = 6,
    parameter int              XLEN          = 32,
    parameter int              FLUSH_LEN     = 1,
    parameter int              STALL_TIMEOUT = 1024,
    parameter logic [XLEN-1:0] VEC_INT       = 'h20,
    parameter logic [XLEN-1:0] VEC_GEN       = 'h40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [XLEN-1:0]   cp0_epc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic [XLEN-1:0]   new_pc_o,
    output logic              pc_load_o,
    output logic              busy_o,
    output logic              stall_timeout_o
);

    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int WDW = $clog2(STALL_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              to_q, to_d;
    logic [NSTAGE-1:0] therm;
    logic [XLEN-1:0]   target_sel;
    logic              stalling;

    stall_thermo #(.N(NSTAGE)) u_thermo (
        .req_i   (stallreq_i),
        .therm_o (therm)
    );

    always_comb begin
        target_sel = VEC_GEN;
        case (exc_vec_sel(excepttype_i))
            VSEL_INT: target_sel = VEC_INT;
            VSEL_EPC: target_sel = cp0_epc_i;
            default:  target_sel = VEC_GEN;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (excepttype_i != ZERO_WORD) begin
                    state_d  = ST_FREEZE;
                    target_d = target_sel;
                end
            end
            ST_FREEZE: begin
                state_d = ST_FLUSH;
                fcnt_d  = '0;
            end
            ST_FLUSH: begin
                if (fcnt_q == FCW'(FLUSH_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q + FCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog only counts genuine stage-requested stalls, not the FREEZE hold.
    always_comb begin
        stalling = (state_q == ST_IDLE) && (|therm);
        wd_d     = '0;
        if (stalling) begin
            wd_d = (wd_q == WDW'(STALL_TIMEOUT)) ? wd_q : wd_q + WDW'(1);
        end
        to_d = to_q | (wd_d == WDW'(STALL_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= '0;
            target_q <= '0;
            wd_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            target_q <= target_d;
            wd_q     <= wd_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        stall_o         = '0;
        flush_o         = (state_q == ST_FLUSH);
        pc_load_o       = flush_o && (fcnt_q == '0);
        new_pc_o        = flush_o ? target_q : XLEN'(ZERO_WORD);
        busy_o          = (state_q != ST_IDLE);
        stall_timeout_o = to_q;
        if (state_q == ST_IDLE) begin
            stall_o = therm;
        end else if (state_q == ST_FREEZE) begin
            stall_o = '1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - bench for pipeline_ctrl with FLUSH_LEN=1 and FLUSH_LEN=3 instances
module tb_pipeline_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;

    logic [5:0]  o_stall [2];
    logic        o_flush [2];
    logic [31:0] o_pc    [2];
    logic        o_load  [2];
    logic        o_busy  [2];
    logic        o_to    [2];

    int checks;
    int failures;

    int          m_left [2];
    logic [31:0] m_tgt  [2];
    int          m_wd   [2];
    bit          m_to   [2];
    int          fl_len [2];

    typedef struct {
        logic        r;
        logic [5:0]  req;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        load;
        logic        busy;
        logic        to;
    } vec_t;

    vec_t tv [22];

    pipeline_ctrl #(.NSTAGE(6), .XLEN(32), .FLUSH_LEN(1), .STALL_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(excepttype),
        .cp0_epc_i(cp0_epc), .stall_o(o_stall[0]), .flush_o(o_flush[0]),
        .new_pc_o(o_pc[0]), .pc_load_o(o_load[0]), .busy_o(o_busy[0]),
        .stall_timeout_o(o_to[0])
    );

    pipeline_ctrl #(.NSTAGE(6), .XLEN(32), .FLUSH_LEN(3), .STALL_TIMEOUT(TO)) dut3 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(excepttype),
        .cp0_epc_i(cp0_epc), .stall_o(o_stall[1]), .flush_o(o_flush[1]),
        .new_pc_o(o_pc[1]), .pc_load_o(o_load[1]), .busy_o(o_busy[1]),
        .stall_timeout_o(o_to[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] thermo(input logic [5:0] r);
        int h = -1;
        for (int i = 0; i < 6; i++) if (r[i]) h = i;
        if (h < 0) return 6'd0;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    function automatic logic [31:0] vec_of(input logic [31:0] code, input logic [31:0] epc);
        if (code == 32'h01) return 32'h20;
        if (code == 32'h0e) return epc;
        return 32'h40;
    endfunction

    // m_left counts cycles until idle: FL+1 = freeze, FL..1 = flush, 0 = idle.
    task automatic check_model(input int d);
        bit          idle, frz, fls;
        logic [5:0]  es;
        idle = (m_left[d] == 0);
        frz  = (m_left[d] == fl_len[d] + 1);
        fls  = !idle && !frz;
        es   = idle ? thermo(stallreq) : (frz ? 6'h3f : 6'h00);
        chk($sformatf("model dut%0d stall", d), 64'(o_stall[d]), 64'(es));
        chk($sformatf("model dut%0d flush", d), 64'(o_flush[d]), 64'(fls));
        chk($sformatf("model dut%0d new_pc", d), 64'(o_pc[d]), fls ? 64'(m_tgt[d]) : 64'd0);
        chk($sformatf("model dut%0d pc_load", d), 64'(o_load[d]), 64'(fls && m_left[d] == fl_len[d]));
        chk($sformatf("model dut%0d busy", d), 64'(o_busy[d]), 64'(!idle));
        chk($sformatf("model dut%0d timeout", d), 64'(o_to[d]), 64'(m_to[d]));
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_left[d] = 0;
                m_tgt[d]  = 0;
                m_wd[d]   = 0;
                m_to[d]   = 0;
            end else begin
                if (m_left[d] == 0 && stallreq != 0) begin
                    if (m_wd[d] < TO) m_wd[d]++;
                    if (m_wd[d] == TO) m_to[d] = 1;
                end else begin
                    m_wd[d] = 0;
                end
                if (m_left[d] == 0 && excepttype != 0) begin
                    m_left[d] = fl_len[d] + 1;
                    m_tgt[d]  = vec_of(excepttype, cp0_epc);
                end else if (m_left[d] > 0) begin
                    m_left[d]--;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] req, input logic [31:0] exc,
                         input logic [31:0] epc);
        @(negedge clk);
        rst        = r;
        stallreq   = req;
        excepttype = exc;
        cp0_epc    = epc;
        #1;
        check_model(0);
        check_model(1);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic [5:0]  rreq;
        logic [31:0] codes [7];
        checks = 0;
        failures = 0;
        fl_len[0] = 1;
        fl_len[1] = 3;
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_tgt[d] = 0; m_wd[d] = 0; m_to[d] = 0;
        end
        rst = 1'b1; stallreq = '0; excepttype = '0; cp0_epc = '0;
        repeat (2) @(posedge clk);

        tv[0]  = '{1'b1, 6'h00, 32'h00, 32'h0000, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 6'h04, 32'h00, 32'h0000, 6'h07, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 6'h08, 32'h00, 32'h0000, 6'h0f, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 6'h29, 32'h00, 32'h0000, 6'h3f, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 6'h00, 32'h08, 32'h0000, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 6'h00, 32'h00, 32'h0000, 6'h3f, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 6'h00, 32'h00, 32'h0000, 6'h00, 1'b1, 32'h0040, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 6'h00, 32'h00, 32'h0000, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 6'h01, 32'h01, 32'h0000, 6'h01, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 6'h01, 32'h0c, 32'h0000, 6'h3f, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b0, 6'h01, 32'h0c, 32'h0000, 6'h00, 1'b1, 32'h0020, 1'b1, 1'b1, 1'b0};
        tv[11] = '{1'b0, 6'h00, 32'h00, 32'h0000, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        for (int i = 12; i < 16; i++)
            tv[i] = '{1'b0, 6'h02, 32'h00, 32'h0000, 6'h03, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};
        tv[16] = '{1'b0, 6'h02, 32'h00, 32'h0000, 6'h03, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1};
        tv[17] = '{1'b0, 6'h00, 32'h00, 32'h0000, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1};
        tv[18] = '{1'b0, 6'h00, 32'h0e, 32'h1234, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1};
        tv[19] = '{1'b0, 6'h00, 32'h00, 32'h5678, 6'h3f, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b1};
        tv[20] = '{1'b1, 6'h00, 32'h00, 32'h5678, 6'h00, 1'b1, 32'h1234, 1'b1, 1'b1, 1'b1};
        tv[21] = '{1'b0, 6'h00, 32'h00, 32'h5678, 6'h00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            drive(tv[i].r, tv[i].req, tv[i].exc, tv[i].epc);
            chk($sformatf("tv%0d stall", i), 64'(o_stall[0]), 64'(tv[i].stall));
            chk($sformatf("tv%0d flush", i), 64'(o_flush[0]), 64'(tv[i].flush));
            chk($sformatf("tv%0d new_pc", i), 64'(o_pc[0]), 64'(tv[i].pc));
            chk($sformatf("tv%0d pc_load", i), 64'(o_load[0]), 64'(tv[i].load));
            chk($sformatf("tv%0d busy", i), 64'(o_busy[0]), 64'(tv[i].busy));
            chk($sformatf("tv%0d timeout", i), 64'(o_to[0]), 64'(tv[i].to));
            advance();
        end

        // FLUSH_LEN=3: eret target is captured at detection, not tracked afterwards.
        drive(1'b0, 6'h00, 32'h0e, 32'h1234);
        advance();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 6'h00, 32'h00, 32'h5678);
            chk($sformatf("eret k%0d new_pc", k), 64'(o_pc[1]),
                (k >= 2 && k <= 4) ? 64'h1234 : 64'h0);
            chk($sformatf("eret k%0d flush", k), 64'(o_flush[1]), 64'(k >= 2 && k <= 4));
            chk($sformatf("eret k%0d pc_load", k), 64'(o_load[1]), 64'(k == 2));
            advance();
        end

        // Exception on the last FLUSH cycle is dropped; the next IDLE cycle accepts one.
        drive(1'b0, 6'h00, 32'h08, 32'h0);
        advance();
        drive(1'b0, 6'h00, 32'h00, 32'h0);
        advance();
        drive(1'b0, 6'h00, 32'h01, 32'h0);
        chk("edge dut1 flush", 64'(o_flush[0]), 64'd1);
        advance();
        drive(1'b0, 6'h00, 32'h01, 32'h0);
        chk("edge dut1 busy", 64'(o_busy[0]), 64'd0);
        advance();
        drive(1'b0, 6'h00, 32'h00, 32'h0);
        chk("edge dut1 freeze", 64'(o_stall[0]), 64'h3f);
        advance();
        drive(1'b0, 6'h00, 32'h00, 32'h0);
        chk("edge dut1 new_pc", 64'(o_pc[0]), 64'h20);
        advance();

        codes[0] = 32'h01; codes[1] = 32'h08; codes[2] = 32'h0a; codes[3] = 32'h0c;
        codes[4] = 32'h0d; codes[5] = 32'h0e; codes[6] = 32'h0;
        rreq = 6'h0;
        for (int n = 0; n < 500; n++) begin
            logic        rr;
            logic [31:0] ex;
            int          ci;
            rr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0)
                rreq = ($urandom_range(0, 2) == 0) ? 6'h0 : 6'($urandom);
            ex = 32'h0;
            if ($urandom_range(0, 6) == 0) begin
                ci = $urandom_range(0, 6);
                ex = (ci == 6) ? ($urandom | 32'h100) : codes[ci];
            end
            drive(rr, rreq, ex, $urandom);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
